// File: rtl/ddr3_app_traffic_gen.sv
// Traffic generator for the DDR3 MIG app_* interface. It writes a deterministic pattern to a
// block of bursts, reads the block back and compares every beat against the same pattern.
module ddr3_app_traffic_gen #(
  parameter int          ADDR_WIDTH  = 32'd28,
  parameter int          DATA_WIDTH  = 32'd256,
  parameter int          MASK_WIDTH  = 32'd32,
  parameter int          NUM_BURSTS  = 32'd256,
  parameter int unsigned BASE_ADDR   = 32'd0,
  parameter int unsigned ADDR_STEP   = 32'd8,
  parameter logic [31:0] PATTERN_XOR = 32'h0000_0000,
  parameter bit          LOOP        = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_calib_complete,
  input  logic                  tg_enable,
  input  logic                  app_rdy,
  input  logic                  app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0] app_rd_data,
  input  logic                  app_rd_data_valid,
  input  logic                  app_rd_data_end,
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic [DATA_WIDTH-1:0] app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [MASK_WIDTH-1:0] app_wdf_mask,
  output logic                  tg_compare_error,
  output logic [ADDR_WIDTH-1:0] tg_err_addr,
  output logic                  tg_pass_done,
  output logic [15:0]           tg_pass_count,
  output logic                  tg_busy
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_READ  = 2'b10;
  localparam logic [1:0] ST_CHECK = 2'b11;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam int              LANES   = DATA_WIDTH / 32;
  localparam logic [21:0]     LP_NB   = 22'(NUM_BURSTS);
  localparam logic [21:0]     LP_LAST = LP_NB - 22'd1;
  localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LP_STEP = ADDR_WIDTH'(ADDR_STEP);

  // Lane j of burst k carries {pass, k, j}, so a misplaced or stale beat never aliases a good one
  function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [7:0] pass, input logic [20:0] burst);
    logic [DATA_WIDTH-1:0] word;
    word = '0;
    for (int j = 0; j < LANES; j++) begin
      word[32*j +: 32] = PATTERN_XOR ^ {pass, burst, 3'(j)};
    end
    return word;
  endfunction

  logic [1:0]            r_state;
  logic                  r_busy;
  logic                  r_app_en;
  logic [2:0]            r_app_cmd;
  logic [ADDR_WIDTH-1:0] r_app_addr;
  logic [DATA_WIDTH-1:0] r_wdf_data;
  logic                  r_wdf_wren;
  logic                  r_cmd_done;
  logic                  r_dat_done;
  logic [21:0]           r_wr_k;
  logic [21:0]           r_rd_iss;
  logic [21:0]           r_rcv;
  logic [ADDR_WIDTH-1:0] r_rcv_addr;
  logic [15:0]           r_pass_count;
  logic                  r_pass_done;
  logic                  r_cmp_vld;
  logic                  r_cmp_oos;
  logic [DATA_WIDTH-1:0] r_cmp_data;
  logic [DATA_WIDTH-1:0] r_cmp_exp;
  logic [ADDR_WIDTH-1:0] r_cmp_addr;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_err_addr;

  logic                  w_cmd_acc;
  logic                  w_dat_acc;
  logic                  w_wr_both;
  logic                  w_rcv_ok;
  logic [21:0]           w_wr_k_nxt;
  logic [15:0]           w_pass_nxt;
  logic                  w_unused;

  assign w_cmd_acc  = r_app_en & app_rdy;
  assign w_dat_acc  = r_wdf_wren & app_wdf_rdy;
  assign w_wr_both  = (r_cmd_done | w_cmd_acc) & (r_dat_done | w_dat_acc);
  assign w_rcv_ok   = app_rd_data_valid & (r_state == ST_READ) & (r_rcv != LP_NB);
  assign w_wr_k_nxt = r_wr_k + 22'd1;
  assign w_pass_nxt = r_pass_count + 16'd1;
  assign w_unused   = app_rd_data_end;

  // Sequencer: write phase, read phase with concurrent return counting, and pass bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_app_en     <= 1'b0;
      r_app_cmd    <= CMD_RD;
      r_app_addr   <= LP_BASE;
      r_wdf_data   <= '0;
      r_wdf_wren   <= 1'b0;
      r_cmd_done   <= 1'b0;
      r_dat_done   <= 1'b0;
      r_wr_k       <= 22'd0;
      r_rd_iss     <= 22'd0;
      r_rcv        <= 22'd0;
      r_rcv_addr   <= LP_BASE;
      r_pass_count <= 16'd0;
      r_pass_done  <= 1'b0;
    end else begin
      r_pass_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (init_calib_complete && tg_enable) begin
            r_state    <= ST_WRITE;
            r_busy     <= 1'b1;
            r_app_en   <= 1'b1;
            r_app_cmd  <= CMD_WR;
            r_app_addr <= LP_BASE;
            r_wdf_data <= f_pattern(r_pass_count[7:0], 21'd0);
            r_wdf_wren <= 1'b1;
            r_cmd_done <= 1'b0;
            r_dat_done <= 1'b0;
            r_wr_k     <= 22'd0;
          end
        end
        ST_WRITE: begin
          if (w_wr_both) begin
            r_cmd_done <= 1'b0;
            r_dat_done <= 1'b0;
            if (r_wr_k == LP_LAST) begin
              r_state    <= ST_READ;
              r_wr_k     <= 22'd0;
              r_app_en   <= 1'b1;
              r_app_cmd  <= CMD_RD;
              r_app_addr <= LP_BASE;
              r_wdf_wren <= 1'b0;
              r_rd_iss   <= 22'd0;
              r_rcv      <= 22'd0;
              r_rcv_addr <= LP_BASE;
            end else begin
              r_wr_k     <= w_wr_k_nxt;
              r_app_en   <= 1'b1;
              r_app_addr <= r_app_addr + LP_STEP;
              r_wdf_data <= f_pattern(r_pass_count[7:0], w_wr_k_nxt[20:0]);
              r_wdf_wren <= 1'b1;
            end
          end else begin
            // Each side drops on its own acceptance and waits for the other
            if (w_cmd_acc) begin
              r_app_en   <= 1'b0;
              r_cmd_done <= 1'b1;
            end
            if (w_dat_acc) begin
              r_wdf_wren <= 1'b0;
              r_dat_done <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (w_cmd_acc) begin
            r_rd_iss <= r_rd_iss + 22'd1;
            if (r_rd_iss == LP_LAST) begin
              r_app_en <= 1'b0;
            end else begin
              r_app_addr <= r_app_addr + LP_STEP;
            end
          end
          if (w_rcv_ok) begin
            r_rcv      <= r_rcv + 22'd1;
            r_rcv_addr <= r_rcv_addr + LP_STEP;
          end
          if (r_rcv == LP_NB) begin
            r_state  <= ST_CHECK;
            r_app_en <= 1'b0;
          end
        end
        ST_CHECK: begin
          r_pass_done  <= 1'b1;
          r_pass_count <= w_pass_nxt;
          if (LOOP && tg_enable) begin
            r_state    <= ST_WRITE;
            r_app_en   <= 1'b1;
            r_app_cmd  <= CMD_WR;
            r_app_addr <= LP_BASE;
            r_wdf_data <= f_pattern(w_pass_nxt[7:0], 21'd0);
            r_wdf_wren <= 1'b1;
            r_cmd_done <= 1'b0;
            r_dat_done <= 1'b0;
            r_wr_k     <= 22'd0;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_app_en   <= 1'b0;
          r_wdf_wren <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage compare: capture beat and expectation, then judge and latch the first failing address
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp_vld  <= 1'b0;
      r_cmp_oos  <= 1'b0;
      r_cmp_data <= '0;
      r_cmp_exp  <= '0;
      r_cmp_addr <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_cmp_vld <= app_rd_data_valid;
      r_cmp_oos <= app_rd_data_valid & ~w_rcv_ok;
      if (app_rd_data_valid) begin
        r_cmp_data <= app_rd_data;
        r_cmp_exp  <= f_pattern(r_pass_count[7:0], r_rcv[20:0]);
        r_cmp_addr <= r_rcv_addr;
      end
      if (r_cmp_vld && (r_cmp_oos || (r_cmp_data != r_cmp_exp))) begin
        r_err <= 1'b1;
        if (!r_err && !r_cmp_oos) begin
          r_err_addr <= r_cmp_addr;
        end
      end
    end
  end

  assign app_en           = r_app_en;
  assign app_cmd          = r_app_cmd;
  assign app_addr         = r_app_addr;
  assign app_wdf_data     = r_wdf_data;
  assign app_wdf_wren     = r_wdf_wren;
  assign app_wdf_end      = r_wdf_wren;
  assign app_wdf_mask     = {MASK_WIDTH{1'b0}};
  assign tg_compare_error = r_err;
  assign tg_err_addr      = r_err_addr;
  assign tg_pass_done     = r_pass_done;
  assign tg_pass_count    = r_pass_count;
  assign tg_busy          = r_busy;

endmodule

// File: tb/tb_ddr3_app_traffic_gen.sv
// Bench for ddr3_app_traffic_gen: a zero-latency memory model pairs write command/data beats,
// checks them against a scoreboard of expected writes and returns reads with optional corruption.
module tb_ddr3_app_traffic_gen;

  localparam int AW = 28;
  localparam int DW = 256;
  localparam int MW = 32;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_calib_complete;
  logic          tg_enable;
  logic          app_rdy;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [MW-1:0] app_wdf_mask;
  logic          tg_compare_error;
  logic [AW-1:0] tg_err_addr;
  logic          tg_pass_done;
  logic [15:0]   tg_pass_count;
  logic          tg_busy;

  ddr3_app_traffic_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .NUM_BURSTS(NB),
    .BASE_ADDR(32'd0), .ADDR_STEP(32'd8), .PATTERN_XOR(32'h0000_0000), .LOOP(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete), .tg_enable(tg_enable),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_wdf_data(app_wdf_data),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
    .tg_compare_error(tg_compare_error), .tg_err_addr(tg_err_addr), .tg_pass_done(tg_pass_done),
    .tg_pass_count(tg_pass_count), .tg_busy(tg_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           sb_q[$];
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            rd_q[$];
  int            wr_cyc[$];
  logic [DW-1:0] mem [0:NB-1];
  logic [31:0]   wr_lane0 [0:NB-1];

  int n_cmp = 0;
  int n_bad = 0;
  int stall_cnt = 0;
  bit stall_on = 1'b0;
  int stall_wd = 0;
  int pass_wr = 0;
  int flip_k = -1;
  int stale_k = -1;
  int flip_cyc = -1;
  int err_rise_cyc = -1;
  bit inject_oos = 1'b0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int p, input int k);
    logic [DW-1:0] d;
    for (int j = 0; j < DW / 32; j++) begin
      d[32*j +: 32] = 32'h0000_0000 ^ ((32'(p & 255) << 24) | (32'(k) << 3) | 32'(j));
    end
    return d;
  endfunction

  // Memory model: stall/ready control, read return one cycle after acceptance, write pairing
  initial begin
    int            k;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    wr_t           e;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    app_rd_data_valid = 1'b0;
    app_rd_data_end = 1'b0;
    app_rd_data = '0;
    forever begin
      @(negedge clk);
      if (stall_cnt > 0 && (app_en || stall_on)) begin
        stall_on = 1'b1;
        app_rdy = 1'b0;
        stall_cnt--;
        check_eq("stall_en_held", app_en, 1'b1);
        check_eq("stall_addr_stable", app_addr, '0);
      end else begin
        stall_on = 1'b0;
        app_rdy = 1'b1;
      end
      app_rd_data_valid = 1'b0;
      app_rd_data_end = 1'b0;
      if (rd_q.size() > 0) begin
        k = rd_q.pop_front();
        d = mem[k];
        if (k == flip_k) begin
          d[0] = ~d[0];
          flip_cyc = cyc;
        end
        if (k == stale_k) d = pat(0, k);
        app_rd_data = d;
        app_rd_data_valid = 1'b1;
        app_rd_data_end = 1'b1;
      end else if (inject_oos) begin
        inject_oos = 1'b0;
        app_rd_data = pat(0, 0);
        app_rd_data_valid = 1'b1;
        app_rd_data_end = 1'b1;
      end
      if (!rst) begin
        if (app_en && app_rdy) begin
          if (app_cmd == 3'b000) begin
            wa_q.push_back(app_addr);
          end else begin
            check_eq("rd_cmd", app_cmd, 3'b001);
            rd_q.push_back(int'(app_addr[4:3]));
          end
        end
        if (app_wdf_wren && app_wdf_rdy) begin
          check_eq("wdf_end", app_wdf_end, 1'b1);
          check_eq("wdf_mask", app_wdf_mask, '0);
          wd_q.push_back(app_wdf_data);
          if (stall_on) stall_wd++;
        end
        while (wa_q.size() > 0 && wd_q.size() > 0) begin
          a = wa_q.pop_front();
          d = wd_q.pop_front();
          pass_wr++;
          wr_cyc.push_back(cyc);
          mem[a[4:3]] = d;
          wr_lane0[a[4:3]] = d[31:0];
          check_eq("wr_expected", sb_q.size() != 0, 1'b1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("wr_addr", a, e.addr);
            check_eq("wr_data", d, e.data);
          end
        end
      end
    end
  end

  task automatic push_pass(input int p);
    for (int k = 0; k < NB; k++) sb_q.push_back('{addr: AW'(k * 8), data: pat(p, k)});
    pass_wr = 0;
    wr_cyc.delete();
  endtask

  task automatic wait_pass(input int exp_count);
    int n_done = 0;
    int t = 0;
    int post = 0;
    bit prev_err;
    prev_err = tg_compare_error;
    while (post < 3 && t < 400) begin
      @(negedge clk); #1;
      t++;
      if (tg_busy) tg_enable = 1'b0;
      if (tg_pass_done) n_done++;
      if (!prev_err && tg_compare_error) err_rise_cyc = cyc;
      prev_err = tg_compare_error;
      if (n_done > 0) post++;
    end
    check_eq("pass_done_pulses", n_done, 1);
    check_eq("pass_count", tg_pass_count, exp_count);
    check_eq("pass_writes", pass_wr, NB);
    check_eq("pass_idle", tg_busy, 1'b0);
  endtask

  task automatic run_pass(input int p, input int exp_count);
    push_pass(p);
    tg_enable = 1'b1;
    wait_pass(exp_count);
  endtask

  task automatic flush_model();
    sb_q.delete();
    wa_q.delete();
    wd_q.delete();
    rd_q.delete();
  endtask

  initial begin
    int seen;
    int lat;
    rst = 1'b1;
    init_calib_complete = 1'b0;
    tg_enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_app_en", app_en, 1'b0);
    check_eq("rst_app_cmd", app_cmd, 3'b001);
    check_eq("rst_app_addr", app_addr, '0);
    check_eq("rst_wren", app_wdf_wren, 1'b0);
    check_eq("rst_err", tg_compare_error, 1'b0);
    check_eq("rst_count", tg_pass_count, 16'd0);
    check_eq("rst_busy", tg_busy, 1'b0);
    check_eq("rst_done", tg_pass_done, 1'b0);
    rst = 1'b0;

    // Calibration held low: enabled but nothing may start
    tg_enable = 1'b1;
    seen = 0;
    repeat (100) begin
      @(negedge clk); #1;
      if (app_en || tg_busy) seen++;
    end
    check_eq("calib_hold", seen, 0);
    push_pass(0);
    init_calib_complete = 1'b1;
    lat = 0;
    while (!app_en && lat < 10) begin
      @(negedge clk); #1;
      lat++;
    end
    check_eq("calib_start_latency", (lat <= 2) && app_en, 1'b1);
    wait_pass(1);
    check_eq("p0_back_to_back", (wr_cyc.size() == NB) ? wr_cyc[NB-1] - wr_cyc[0] : -1, NB - 1);
    check_eq("p0_b2_lane0", wr_lane0[2], 32'h0000_0010);
    check_eq("p0_err", tg_compare_error, 1'b0);

    // Command side stalled while data side is ready
    stall_cnt = 5;
    stall_wd = 0;
    run_pass(1, 2);
    check_eq("stall_data_once", stall_wd, 1);
    check_eq("p1_b0_lane0", wr_lane0[0], 32'h0100_0000);
    check_eq("p1_err", tg_compare_error, 1'b0);

    // Corrupted beat on burst 3
    flip_k = 3;
    err_rise_cyc = -1;
    run_pass(2, 3);
    flip_k = -1;
    check_eq("flip_err", tg_compare_error, 1'b1);
    check_eq("flip_latency", err_rise_cyc - flip_cyc, 2);
    check_eq("flip_err_addr", tg_err_addr, 28'd24);
    run_pass(3, 4);
    check_eq("err_sticky", tg_compare_error, 1'b1);
    check_eq("err_addr_kept", tg_err_addr, 28'd24);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    flush_model();
    check_eq("rst2_count", tg_pass_count, 16'd0);
    check_eq("rst2_err", tg_compare_error, 1'b0);
    check_eq("rst2_err_addr", tg_err_addr, '0);

    // Stale pass-0 data returned for burst 1 during pass 1
    run_pass(0, 1);
    stale_k = 1;
    run_pass(1, 2);
    stale_k = -1;
    check_eq("stale_err", tg_compare_error, 1'b1);
    check_eq("stale_err_addr", tg_err_addr, 28'd8);

    // Reset while writing burst 2
    push_pass(2);
    tg_enable = 1'b1;
    lat = 0;
    while (!(app_en && app_wdf_wren && app_addr == 28'd16) && lat < 50) begin
      @(negedge clk); #1;
      lat++;
    end
    check_eq("reach_burst2", app_addr, 28'd16);
    rst = 1'b1;
    @(negedge clk); #1;
    check_eq("midrst_app_en", app_en, 1'b0);
    check_eq("midrst_wren", app_wdf_wren, 1'b0);
    check_eq("midrst_count", tg_pass_count, 16'd0);
    check_eq("midrst_err", tg_compare_error, 1'b0);
    rst = 1'b0;
    flush_model();
    push_pass(0);
    lat = 0;
    while (!app_en && lat < 10) begin
      @(negedge clk); #1;
      lat++;
    end
    check_eq("restart_addr", app_addr, '0);
    check_eq("restart_data", app_wdf_data, pat(0, 0));
    wait_pass(1);
    check_eq("restart_err", tg_compare_error, 1'b0);

    // Read data arriving while idle
    inject_oos = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check_eq("oos_err", tg_compare_error, 1'b1);
    check_eq("oos_err_addr", tg_err_addr, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got %0d compares expected completion", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
